// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor: register offsets,
// mtimecmp reset value and the 64-bit word type.
package clint_pkg;

    typedef logic [63:0] dword_t;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    localparam dword_t MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Word-align an in-window offset; byte lanes are not supported.
    function automatic logic [15:0] word_off(input logic [15:0] adr);
        return {adr[15:2], 2'b00};
    endfunction

endpackage

// File: rtl/clint_mtime.sv
// Free-running 64-bit mtime with a PRESCALE divider and per-half write ports.
// A write to either half wins over that cycle's increment.
module clint_mtime
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output dword_t      mtime
);

    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [15:0] pcnt_q, pcnt_d;
    logic        tick_s;
    dword_t      mtime_q, mtime_d;

    // Prescaler wrap and next mtime value.
    always_comb begin
        tick_s = (pcnt_q == PCNT_MAX);
        if (tick_s) begin
            pcnt_d = 16'd0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        if (wr_lo) begin
            mtime_d = {mtime_q[63:32], wdata};
        end else if (wr_hi) begin
            mtime_d = {wdata, mtime_q[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= 16'd0;
            mtime_q <= 64'd0;
        end else begin
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped CLINT on the data-memory port: address decode, read mux,
// mtimecmp/msip storage and registered MTIP/MSIP levels for the trap logic.
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] data_out,
    output logic [31:0] rd_data,
    output logic        hit,
    output logic        machineTimerInterrupt,
    output logic        machineSoftwareInterrupt
);

    logic [15:0] off_s;
    logic        wr_s;
    logic        wr_mtime_lo_s, wr_mtime_hi_s;
    dword_t      mtime_s;
    dword_t      mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic        msip_irq_q, msip_irq_d;
    logic        unused_s;

    // Loads are served whenever addressed, so the read strobe and byte lanes are not needed.
    assign unused_s = ^{mem_read, data_adr[1:0]};

    assign hit           = (data_adr[31:16] == BASE_ADDR[31:16]);
    assign off_s         = word_off(data_adr[15:0]);
    assign wr_s          = mem_write & hit;
    assign wr_mtime_lo_s = wr_s & (off_s == MTIME_LO_OFF);
    assign wr_mtime_hi_s = wr_s & (off_s == MTIME_HI_OFF);

    clint_mtime #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk   (clk),
        .rst   (rst),
        .wr_lo (wr_mtime_lo_s),
        .wr_hi (wr_mtime_hi_s),
        .wdata (data_out),
        .mtime (mtime_s)
    );

    // Zero-latency read mux; anything outside the window or unmapped reads 0.
    always_comb begin
        rd_data = 32'h0;
        if (hit) begin
            case (off_s)
                MSIP_OFF:        rd_data = {31'h0, msip_q};
                MTIMECMP_LO_OFF: rd_data = mtimecmp_q[31:0];
                MTIMECMP_HI_OFF: rd_data = mtimecmp_q[63:32];
                MTIME_LO_OFF:    rd_data = mtime_s[31:0];
                MTIME_HI_OFF:    rd_data = mtime_s[63:32];
                default:         rd_data = 32'h0;
            endcase
        end else begin
            rd_data = 32'h0;
        end
    end

    // Register writes and interrupt conditions, evaluated on pre-edge state.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_s) begin
            case (off_s)
                MSIP_OFF:        msip_d = data_out[0];
                MTIMECMP_LO_OFF: mtimecmp_d = {mtimecmp_q[63:32], data_out};
                MTIMECMP_HI_OFF: mtimecmp_d = {data_out, mtimecmp_q[31:0]};
                default:         mtimecmp_d = mtimecmp_q;
            endcase
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        mtip_d     = (mtime_s >= mtimecmp_q);
        msip_irq_d = msip_q;
    end

    // Register file and interrupt output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            msip_irq_q <= 1'b0;
        end else begin
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            msip_irq_q <= msip_irq_d;
        end
    end

    assign machineTimerInterrupt    = mtip_q;
    assign machineSoftwareInterrupt = msip_irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: two instances (PRESCALE 1 and 4) share one
// stimulus stream and are checked against an arithmetic reference model.
module tb_clint_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] data_adr, data_out;
    logic [31:0] rd_a, rd_b;
    logic        hit_a, hit_b, tip_a, tip_b, sip_a, sip_b;

    always #5 clk = ~clk;

    clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .data_adr(data_adr), .data_out(data_out), .rd_data(rd_a), .hit(hit_a),
        .machineTimerInterrupt(tip_a), .machineSoftwareInterrupt(sip_a));

    clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .data_adr(data_adr), .data_out(data_out), .rd_data(rd_b), .hit(hit_b),
        .machineTimerInterrupt(tip_b), .machineSoftwareInterrupt(sip_b));

    typedef struct packed {
        logic             chk_rd;
        logic [1:0][31:0] rd;
        logic             hit;
        logic [1:0]       tip;
        logic [1:0]       sip;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain integers, updated once per clock edge.
    int          presc [2] = '{1, 4};
    logic [63:0] m_time [2];
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [1:0]  m_tip, m_sip;
    longint      m_cyc;

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:16] == BASE[31:16];
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [31:0] a);
        logic [15:0] o;
        o = a[15:0] & 16'hFFFC;
        if (!m_hit(a)) return 32'h0;
        if (o == 16'h0000) return {31'h0, m_msip};
        if (o == 16'h4000) return m_cmp[31:0];
        if (o == 16'h4004) return m_cmp[63:32];
        if (o == 16'hBFF8) return m_time[i][31:0];
        if (o == 16'hBFFC) return m_time[i][63:32];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m_time[i] = 64'd0;
        m_cmp  = {64{1'b1}};
        m_msip = 1'b0;
        m_tip  = 2'b00;
        m_sip  = 2'b00;
        m_cyc  = 0;
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rs);
        logic [15:0] o;
        logic        we;
        o  = a[15:0] & 16'hFFFC;
        we = w && m_hit(a);
        if (rs) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_tip[i] = (m_time[i] >= m_cmp);
                m_sip[i] = m_msip;
                if (we && o == 16'hBFF8)      m_time[i][31:0]  = d;
                else if (we && o == 16'hBFFC) m_time[i][63:32] = d;
                else if (((m_cyc + 1) % presc[i]) == 0) m_time[i] = m_time[i] + 64'd1;
            end
            if (we && o == 16'h0000) m_msip = d[0];
            if (we && o == 16'h4000) m_cmp[31:0]  = d;
            if (we && o == 16'h4004) m_cmp[63:32] = d;
            m_cyc++;
        end
    endtask

    // One bus cycle: drive inputs, queue the expected outputs, advance the model.
    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rs);
        exp_t e;
        mem_read = r; mem_write = w; data_adr = a; data_out = d; rst = rs;
        e.chk_rd = r;
        e.rd[0]  = m_read(0, a);
        e.rd[1]  = m_read(1, a);
        e.hit    = m_hit(a);
        e.tip    = m_tip;
        e.sip    = m_sip;
        sb.push_back(e);
        @(posedge clk); #1;
        model_step(w, a, d, rs);
    endtask

    task automatic rd(input logic [15:0] off);
        cyc(1'b1, 1'b0, BASE | {16'h0, off}, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] d);
        cyc(1'b0, 1'b1, BASE | {16'h0, off}, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented cycle is popped and compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk_rd) begin
                chk("rd_p1", rd_a, mon_e.rd[0]);
                chk("rd_p4", rd_b, mon_e.rd[1]);
            end
            chk("hit_p1",  {31'h0, hit_a}, {31'h0, mon_e.hit});
            chk("hit_p4",  {31'h0, hit_b}, {31'h0, mon_e.hit});
            chk("mtip_p1", {31'h0, tip_a}, {31'h0, mon_e.tip[0]});
            chk("mtip_p4", {31'h0, tip_b}, {31'h0, mon_e.tip[1]});
            chk("msip_p1", {31'h0, sip_a}, {31'h0, mon_e.sip[0]});
            chk("msip_p4", {31'h0, sip_b}, {31'h0, mon_e.sip[1]});
        end
    end

    initial begin
        logic [31:0] a, d;
        int          sel;
        mem_read = 1'b0; mem_write = 1'b0; data_adr = 32'h0; data_out = 32'h0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset defaults
        rst = 1'b0;
        rd(16'hBFF8); rd(16'h4000); rd(16'h0000); rd(16'h4004);

        // Prescale: 40 cycles after reset
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(40);
        rd(16'hBFF8);

        // Timer interrupt rise and fall
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        wr(16'h4000, 32'd10);
        wr(16'h4004, 32'd0);
        idle(14);
        wr(16'h4000, 32'd1000);
        idle(3);

        // Carry and wrap
        wr(16'hBFFC, 32'hFFFF_FFFF);
        wr(16'hBFF8, 32'hFFFF_FFFE);
        idle(2);
        rd(16'hBFF8); rd(16'hBFFC);
        wr(16'hBFFC, 32'h0000_0007);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        idle(4);
        rd(16'hBFFC);

        // Write beats tick; read-during-write shows the old value
        wr(16'hBFF8, 32'd5);
        rd(16'hBFF8);
        cyc(1'b1, 1'b1, BASE | 32'h4000, 32'h55, 1'b0);
        rd(16'h4000);

        // Software interrupt set and clear
        wr(16'h0000, 32'h1);
        idle(3);
        rd(16'h0000);
        wr(16'h0000, 32'h0);
        idle(3);

        // Decode: unmapped offset and out-of-window store
        cyc(1'b1, 1'b1, BASE | 32'h1000, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 1'b1, 32'h1000_0000, 32'h1, 1'b0);
        cyc(1'b1, 1'b1, 32'h1000_4000, 32'h0, 1'b0);
        rd(16'h0000); rd(16'h4000); rd(16'h1000);

        // Reset wins over a concurrent write
        cyc(1'b0, 1'b1, BASE | 32'h4000, 32'h0, 1'b1);
        rd(16'h4000); rd(16'hBFF8);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: a = BASE | 32'h0000;
                1: a = BASE | 32'h4000;
                2: a = BASE | 32'h4004;
                3: a = BASE | 32'hBFF8;
                4: a = BASE | 32'hBFFC;
                5: a = BASE | 32'h1000;
                6: a = 32'h1000_0000 | 32'($urandom_range(0, 16'hFFFF));
                default: a = BASE | 32'h4002;
            endcase
            if (sel == 2 || sel == 4) d = 32'($urandom_range(0, 1));
            else                      d = 32'($urandom_range(0, 600));
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, d,
                1'($urandom_range(0, 63) == 0));
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
